// File: rtl/dmem_port_if.sv
// Bus bundle for the DMEM port-B arbiter: core (MEM stage) side, host/debug side, BRAM side, debug taps.
// slave = arbiter view, master = environment view (pipeline, host, BRAM).
interface dmem_port_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3
);
    // Handshake: hst_req plus hst_we/addr/wdata stay stable until a cycle with hst_gnt=1, in which
    // the access is performed. Reads return hst_rvalid one cycle later. The core never waits for a
    // grant; cpu_stall=1 means its access was not performed this cycle and must be repeated.
    logic              cpu_re;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;

    logic              hst_req;
    logic [3:0]        hst_we;
    logic [ADDR_W-1:0] hst_addr;
    logic [31:0]       hst_wdata;
    logic              hst_lock;
    logic              hst_gnt;
    logic              hst_rvalid;
    logic [31:0]       hst_rdata;

    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout;

    logic [CNT_W-1:0]  dbg_wait_cnt;
    logic              dbg_locked;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall,
        input  hst_req, hst_we, hst_addr, hst_wdata, hst_lock,
        output hst_gnt, hst_rvalid, hst_rdata,
        output bram_we, bram_addr, bram_din,
        input  bram_dout,
        output dbg_wait_cnt, dbg_locked
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall,
        output hst_req, hst_we, hst_addr, hst_wdata, hst_lock,
        input  hst_gnt, hst_rvalid, hst_rdata,
        input  bram_we, bram_addr, bram_din,
        output bram_dout,
        input  dbg_wait_cnt, dbg_locked
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares BRAM port B between the MEM stage (priority) and a host master with a starvation-forced slot.
// Optional macro HOST_LOCK_EN adds a host burst lock (LOCKED state) that keeps the core stalled.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int HOST_MAX_WAIT = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst,
    dmem_port_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(HOST_MAX_WAIT);

    logic              cpu_act;
    logic              force_slot;
    logic              host_win;
    logic              locked;
    logic              rd_pend;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_sel;

    assign cpu_act    = bus.cpu_re | (|bus.cpu_we);
    assign force_slot = (wait_cnt == MAX_CNT);
    assign host_win   = bus.hst_req & (~cpu_act | force_slot | locked);

`ifdef HOST_LOCK_EN
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;
    lock_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst) state <= UNLOCKED;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: if (host_win && bus.hst_lock) state_next = LOCKED;
            LOCKED:   if (!bus.hst_lock)            state_next = UNLOCKED;
            default:  state_next = UNLOCKED;
        endcase
    end

    assign locked = (state == LOCKED);
`else
    logic unused_lock;
    assign unused_lock = bus.hst_lock;
    assign locked      = 1'b0;
`endif

    // While locked and the host is quiet, the port idles: the stalled core must not write.
    always_comb begin
        bus.hst_gnt   = host_win;
        bus.cpu_stall = cpu_act & (host_win | locked);
        bus.bram_we   = locked ? 4'h0 : bus.cpu_we;
        addr_sel      = bus.cpu_addr;
        bus.bram_din  = bus.cpu_wdata;
        if (host_win) begin
            bus.bram_we  = bus.hst_we;
            addr_sel     = bus.hst_addr;
            bus.bram_din = bus.hst_wdata;
        end
    end

    assign bus.bram_addr = addr_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!bus.hst_req || host_win) begin
            wait_cnt <= '0;
        end else if (cpu_act && wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rdata_q <= '0;
        end else begin
            rd_pend <= host_win & (bus.hst_we == 4'h0);
            if (rd_pend) rdata_q <= bus.bram_dout;
        end
    end

    // Bypass dob during the valid cycle so hst_rdata lines up with hst_rvalid, then hold it.
    assign bus.hst_rvalid   = rd_pend;
    assign bus.hst_rdata    = rd_pend ? bus.bram_dout : rdata_q;
    assign bus.dbg_wait_cnt = wait_cnt;
    assign bus.dbg_locked   = locked;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_port_arbiter;
    localparam int ADDR_W        = 32;
    localparam int HOST_MAX_WAIT = 4;
    localparam int CNT_W         = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    dmem_port_arbiter #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(HOST_MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // BRAM model: read-first, 1-cycle read latency, 256 words
    logic [31:0] mem      [0:255];
    logic [31:0] init_mem [0:255];
    logic        init_req = 1'b0;
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) mem[bus.bram_addr[9:2]][8*b +: 8] <= bus.bram_din[8*b +: 8];
        end
        bus.bram_dout <= mem[bus.bram_addr[9:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q[$];
    int          m_wait;
    bit          m_locked;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    logic        e_gnt, e_stall;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_din;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_re = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.hst_req = 1'b0; bus.hst_we = 4'h0; bus.hst_addr = '0; bus.hst_wdata = '0;
        bus.hst_lock = 1'b0;
    endtask

    task automatic model_reset();
        m_wait = 0; m_locked = 0; m_rvalid = 0; m_rdata = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) begin
            init_mem[i] = $urandom();
            ref_mem[i]  = init_mem[i];
        end
        init_req = 1'b1;
        next_cycle();
        init_req = 1'b0;
    endtask

    // Who owns the port this cycle, from the arbitration rules
    task automatic model_eval();
        bit core;
        bit host_turn;
        core      = bus.cpu_re || (bus.cpu_we != 4'h0);
        host_turn = bus.hst_req && (!core || m_wait >= HOST_MAX_WAIT || m_locked);
        e_gnt     = host_turn;
        e_stall   = core && (host_turn || m_locked);
        if (host_turn) begin
            e_we = bus.hst_we; e_addr = bus.hst_addr; e_din = bus.hst_wdata;
        end else begin
            e_we = m_locked ? 4'h0 : bus.cpu_we; e_addr = bus.cpu_addr; e_din = bus.cpu_wdata;
        end
    endtask

    // Effect of the coming clock edge on memory, starvation count, lock and read return
    task automatic model_commit();
        bit core;
        bit rd;
        core = bus.cpu_re || (bus.cpu_we != 4'h0);
        rd   = e_gnt && (bus.hst_we == 4'h0);
        if (rd) exp_q.push_back(ref_mem[e_addr[9:2]]);
        for (int b = 0; b < 4; b++)
            if (e_we[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_din[8*b +: 8];
        if (!bus.hst_req || e_gnt) m_wait = 0;
        else if (core && m_wait < HOST_MAX_WAIT) m_wait++;
`ifdef HOST_LOCK_EN
        if (m_locked && !bus.hst_lock) m_locked = 0;
        else if (!m_locked && e_gnt && bus.hst_lock) m_locked = 1;
`endif
        m_rvalid = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (bus.hst_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", bus.hst_gnt); end
        n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.cpu_stall); end
        n_tests++; if (bus.hst_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus.hst_rvalid); end
        n_tests++; if (bus.hst_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.hst_rdata); end
        n_tests++; if (bus.dbg_wait_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_wait: got %0d expected 0", bus.dbg_wait_cnt); end
        n_tests++; if (bus.bram_we !== 4'h0) begin n_fail++; $display("FAIL reset_idle_we: got %h expected 0", bus.bram_we); end
        n_tests++; if (bus.dbg_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.dbg_locked); end
        next_cycle();
    endtask

    task automatic test_core_only();
        bus.cpu_we = 4'hF; bus.cpu_addr = 32'h100; bus.cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL core_wr_stall: got %b expected 0", bus.cpu_stall); end
        n_tests++; if (bus.bram_we !== 4'hF) begin n_fail++; $display("FAIL core_wr_we: got %h expected f", bus.bram_we); end
        next_cycle();
        bus.cpu_we = 4'h0; bus.cpu_re = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL core_rd_stall: got %b expected 0", bus.cpu_stall); end
        n_tests++; if (bus.bram_we !== 4'h0) begin n_fail++; $display("FAIL core_rd_we: got %h expected 0", bus.bram_we); end
        next_cycle();
        bus.cpu_re = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.bram_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_rd_data: got %h expected deadbeef", bus.bram_dout); end
        next_cycle();
    endtask

    task automatic test_host_idle_core();
        bus.hst_req = 1'b1; bus.hst_we = 4'h0; bus.hst_addr = 32'h100;
        @(negedge clk);
        n_tests++; if (bus.hst_gnt !== 1'b1) begin n_fail++; $display("FAIL host_idle_gnt: got %b expected 1", bus.hst_gnt); end
        n_tests++; if (bus.bram_addr !== 32'h100) begin n_fail++; $display("FAIL host_idle_addr: got %h expected 100", bus.bram_addr); end
        next_cycle();
        bus.hst_req = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.hst_rvalid !== 1'b1) begin n_fail++; $display("FAIL host_rvalid: got %b expected 1", bus.hst_rvalid); end
        n_tests++; if (bus.hst_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_rdata: got %h expected deadbeef", bus.hst_rdata); end
        next_cycle();
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h3FC;
        @(negedge clk);
        n_tests++; if (bus.hst_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rvalid_drop: got %b expected 0", bus.hst_rvalid); end
        next_cycle();
        bus.cpu_re = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.hst_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL host_rdata_hold: got %h expected deadbeef", bus.hst_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit got;
        do_reset();
        got = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.cpu_re = 1'b1; bus.cpu_addr = 32'h40;
            bus.hst_req = !got; bus.hst_we = 4'hF; bus.hst_addr = 32'h200; bus.hst_wdata = 32'h12345678;
            @(negedge clk);
            n_tests++; if (bus.hst_gnt !== (i == 5)) begin n_fail++; $display("FAIL starve_gnt_c%0d: got %b expected %b", i, bus.hst_gnt, (i == 5)); end
            n_tests++; if (bus.cpu_stall !== (i == 5)) begin n_fail++; $display("FAIL starve_stall_c%0d: got %b expected %b", i, bus.cpu_stall, (i == 5)); end
            if (i <= 5) begin
                n_tests++; if (bus.dbg_wait_cnt !== 3'(i - 1)) begin n_fail++; $display("FAIL starve_wait_c%0d: got %0d expected %0d", i, bus.dbg_wait_cnt, i - 1); end
            end
            if (bus.hst_gnt) got = 1;
            next_cycle();
        end
        idle_inputs();
        n_tests++; if (mem[32'h200 >> 2] !== 32'h12345678) begin n_fail++; $display("FAIL starve_mem: got %h expected 12345678", mem[32'h200 >> 2]); end
    endtask

    task automatic test_collision();
        bit got;
        do_reset();
        got = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.cpu_we = 4'hF; bus.cpu_addr = 32'h300; bus.cpu_wdata = 32'hC0C0C0C0;
            bus.hst_req = !got; bus.hst_we = 4'hF; bus.hst_addr = 32'h300; bus.hst_wdata = 32'h0B0B0B0B;
            @(negedge clk);
            if (i == 6) begin
                n_tests++; if (mem[32'h300 >> 2] !== 32'h0B0B0B0B) begin n_fail++; $display("FAIL collide_host_wins: got %h expected 0b0b0b0b", mem[32'h300 >> 2]); end
                n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL collide_retry_stall: got %b expected 0", bus.cpu_stall); end
            end
            if (i == 5) begin
                n_tests++; if (bus.bram_din !== 32'h0B0B0B0B) begin n_fail++; $display("FAIL collide_force_din: got %h expected 0b0b0b0b", bus.bram_din); end
            end
            if (bus.hst_gnt) got = 1;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_tests++; if (mem[32'h300 >> 2] !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL collide_final: got %h expected c0c0c0c0", mem[32'h300 >> 2]); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        idle_inputs();
        bus.hst_req = 1'b1; bus.hst_we = 4'h0; bus.hst_addr = 32'h100;
        @(negedge clk);
        n_tests++; if (bus.hst_gnt !== 1'b1) begin n_fail++; $display("FAIL rstrd_gnt: got %b expected 1", bus.hst_gnt); end
        next_cycle();
        rst = 1'b1; bus.cpu_re = 1'b1; bus.cpu_addr = 32'h44;
        bus.hst_req = 1'b1; bus.hst_addr = 32'h104;
        @(negedge clk);
        n_tests++; if (bus.hst_gnt !== 1'b0) begin n_fail++; $display("FAIL rstrd_comb_gnt: got %b expected 0", bus.hst_gnt); end
        n_tests++; if (bus.bram_addr !== 32'h44) begin n_fail++; $display("FAIL rstrd_comb_addr: got %h expected 44", bus.bram_addr); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_tests++; if (bus.hst_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstrd_rvalid: got %b expected 0", bus.hst_rvalid); end
        n_tests++; if (bus.hst_rdata !== 32'h0) begin n_fail++; $display("FAIL rstrd_rdata: got %h expected 0", bus.hst_rdata); end
        n_tests++; if (bus.dbg_wait_cnt !== 3'd0) begin n_fail++; $display("FAIL rstrd_wait: got %0d expected 0", bus.dbg_wait_cnt); end
        next_cycle();
    endtask

    task automatic test_random();
        bit h_pend, last_stall;
        logic [31:0] popped;
        load_mem();
        do_reset();
        h_pend = 0; last_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0: begin bus.cpu_re = 1'b0; bus.cpu_we = 4'h0; end
                    1, 3: begin bus.cpu_re = 1'b1; bus.cpu_we = 4'h0; end
                    default: begin bus.cpu_re = 1'b0; bus.cpu_we = 4'($urandom_range(1, 15)); end
                endcase
                bus.cpu_addr  = 32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 10));
                bus.cpu_wdata = $urandom();
            end
            if (h_pend && $urandom_range(0, 15) == 0) h_pend = 0;
            else if (!h_pend && $urandom_range(0, 2) == 0) begin
                h_pend        = 1;
                bus.hst_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                bus.hst_addr  = 32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 12));
                bus.hst_wdata = $urandom();
            end
            bus.hst_req = h_pend;
            @(negedge clk);
            model_eval();
            n_tests++; if (bus.hst_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, bus.hst_gnt, e_gnt); end
            n_tests++; if (bus.cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", cyc, bus.cpu_stall, e_stall); end
            n_tests++; if (bus.bram_we !== e_we) begin n_fail++; $display("FAIL rnd_we c%0d: got %h expected %h", cyc, bus.bram_we, e_we); end
            n_tests++; if (bus.bram_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h expected %h", cyc, bus.bram_addr, e_addr); end
            n_tests++; if (bus.bram_din !== e_din) begin n_fail++; $display("FAIL rnd_din c%0d: got %h expected %h", cyc, bus.bram_din, e_din); end
            n_tests++; if (bus.dbg_wait_cnt !== 3'(m_wait)) begin n_fail++; $display("FAIL rnd_wait c%0d: got %0d expected %0d", cyc, bus.dbg_wait_cnt, m_wait); end
            n_tests++; if (bus.hst_rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", cyc, bus.hst_rvalid, m_rvalid); end
            if (m_rvalid && exp_q.size() > 0) begin
                popped  = exp_q.pop_front();
                m_rdata = popped;
            end
            n_tests++; if (bus.hst_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, bus.hst_rdata, m_rdata); end
            model_commit();
            if (e_gnt) h_pend = 0;
            last_stall = e_stall;
            next_cycle();
        end
        idle_inputs();
    endtask

`ifdef HOST_LOCK_EN
    task automatic test_lock();
        logic [31:0] d [8];
        int stalls;
        bit got;
        do_reset();
        stalls = 0;
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h80; bus.hst_lock = 1'b1;
        for (int w = 0; w < 8; w++) begin
            d[w] = $urandom();
            bus.hst_req = 1'b1; bus.hst_we = 4'hF; bus.hst_addr = 32'(w * 4); bus.hst_wdata = d[w];
            got = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (bus.cpu_stall) stalls++;
                got = bus.hst_gnt;
                next_cycle();
            end
            n_tests++; if (!got) begin n_fail++; $display("FAIL lock_gnt w%0d: got no grant expected grant within 8 cycles", w); end
        end
        bus.hst_req = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lock_idle_stall: got %b expected 1", bus.cpu_stall); end
        n_tests++; if (bus.bram_we !== 4'h0) begin n_fail++; $display("FAIL lock_idle_we: got %h expected 0", bus.bram_we); end
        next_cycle();
        bus.hst_lock = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lock_release_stall: got %b expected 1", bus.cpu_stall); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL lock_resume_stall: got %b expected 0", bus.cpu_stall); end
        n_tests++; if (bus.dbg_locked !== 1'b0) begin n_fail++; $display("FAIL lock_exit: got %b expected 0", bus.dbg_locked); end
        n_tests++; if (stalls < 8) begin n_fail++; $display("FAIL lock_stall_cycles: got %0d expected >=8", stalls); end
        for (int w = 0; w < 8; w++) begin
            n_tests++; if (mem[w] !== d[w]) begin n_fail++; $display("FAIL lock_mem w%0d: got %h expected %h", w, mem[w], d[w]); end
        end
        next_cycle();
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        load_mem();
        do_reset();
        test_reset();
        test_core_only();
        test_host_idle_core();
        test_starvation();
        test_collision();
        test_reset_mid_read();
        test_random();
`ifdef HOST_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
